// File: rtl/dbf_scan_sequencer_pkg.sv
// Shared widths, state encoding and the phase-selection helper for the DBF scan sequencer.
package dbf_scan_sequencer_pkg;

  localparam int ADDR_WD = 10;
  localparam int CNT_WD  = 8;
  localparam int LINE_WD = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TX   = 3'd2,
    S_DEAD = 3'd3,
    S_RX   = 3'd4
  } state_t;

  // First phase of a scanline: zero-length TX/DEAD phases are skipped, RX always runs.
  function automatic state_t first_phase(input logic [CNT_WD-1:0] tx_len,
                                         input logic [CNT_WD-1:0] dead_len);
    state_t ph;
    if (tx_len != '0)        ph = S_TX;
    else if (dead_len != '0) ph = S_DEAD;
    else                     ph = S_RX;
    return ph;
  endfunction

endpackage

// File: rtl/dbf_scan_sequencer_if.sv
// Control/LUT bus between the host/system side (master) and the scan sequencer (slave).
interface dbf_scan_sequencer_if;
  import dbf_scan_sequencer_pkg::*;

  logic               scan_trig;
  logic [LINE_WD-1:0] num_lines;
  logic [CNT_WD-1:0]  tx_len;
  logic [CNT_WD-1:0]  dead_len;
  logic [ADDR_WD-1:0] rx_len;
  logic               load_req;
  logic               load_valid;
  logic [ADDR_WD-1:0] load_addr;
  logic               load_gnt;
  logic               tx_en;
  logic               start;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic               dbf_lut_we;
  logic [LINE_WD-1:0] line_idx;
  logic               line_done;
  logic               frame_done;
  logic               busy;
  logic               trig_err;

  modport master (
    output scan_trig, num_lines, tx_len, dead_len, rx_len, load_req, load_valid, load_addr,
    input  load_gnt, tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx, line_done,
           frame_done, busy, trig_err
  );

  modport slave (
    input  scan_trig, num_lines, tx_len, dead_len, rx_len, load_req, load_valid, load_addr,
    output load_gnt, tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx, line_done,
           frame_done, busy, trig_err
  );

endinterface

// File: rtl/dbf_scan_sequencer_cnt.sv
// Loadable saturating down-counter; last flags the final cycle of a phase.
module dbf_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld)                     cnt_d = ld_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/dbf_scan_sequencer.sv
// Frame sequencer for the DBF channel array: TX/DEAD/RX per scanline plus host LUT-load arbitration.
module dbf_scan_sequencer
  import dbf_scan_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dbf_scan_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [LINE_WD-1:0] num_lines_q, num_lines_d;
  logic [CNT_WD-1:0]  tx_len_q, tx_len_d, dead_len_q, dead_len_d;
  logic [ADDR_WD-1:0] rx_len_q, rx_len_d;
  logic [LINE_WD-1:0] line_idx_q, line_idx_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic tx_en_q, tx_en_d, start_q, start_d, we_q, we_d, gnt_q, gnt_d, busy_q, busy_d;
  logic line_done_q, line_done_d, frame_done_q, frame_done_d, trig_err_q, trig_err_d;

  logic [LINE_WD-1:0] nl_cfg;
  logic [CNT_WD-1:0]  tx_cfg, dead_cfg;
  logic [ADDR_WD-1:0] rx_cfg;
  logic accept, tx_last, dead_last, rx_last, tx_ld, dead_ld, rx_ld;

  // In IDLE the config comes straight from the inputs so the first line can start without a bubble.
  always_comb begin
    nl_cfg   = num_lines_q;
    tx_cfg   = tx_len_q;
    dead_cfg = dead_len_q;
    rx_cfg   = rx_len_q;
    if (state_q == S_IDLE) begin
      nl_cfg   = (bus.num_lines == '0) ? LINE_WD'(1) : bus.num_lines;
      tx_cfg   = bus.tx_len;
      dead_cfg = bus.dead_len;
      rx_cfg   = (bus.rx_len == '0) ? ADDR_WD'(1) : bus.rx_len;
    end
  end

  assign accept      = (state_q == S_IDLE) && bus.scan_trig && !bus.load_req;
  assign num_lines_d = accept ? nl_cfg   : num_lines_q;
  assign tx_len_d    = accept ? tx_cfg   : tx_len_q;
  assign dead_len_d  = accept ? dead_cfg : dead_len_q;
  assign rx_len_d    = accept ? rx_cfg   : rx_len_q;

  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load_req) begin
          state_d = S_LOAD;
        end else if (bus.scan_trig) begin
          state_d    = first_phase(tx_cfg, dead_cfg);
          line_idx_d = '0;
        end
      end
      S_LOAD: if (!bus.load_req) state_d = S_IDLE;
      S_TX:   if (tx_last) state_d = (dead_cfg != '0) ? S_DEAD : S_RX;
      S_DEAD: if (dead_last) state_d = S_RX;
      S_RX: begin
        if (rx_last) begin
          if (line_idx_q == nl_cfg - LINE_WD'(1)) begin
            state_d = S_IDLE;
          end else begin
            line_idx_d = line_idx_q + LINE_WD'(1);
            state_d    = first_phase(tx_cfg, dead_cfg);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE || state_d == S_LOAD) line_idx_d = '0;
  end

  // A phase counter reloads on entry, including RX->RX when TX and DEAD are both zero-length.
  assign tx_ld   = (state_d == S_TX)   && ((state_q != S_TX)   || tx_last);
  assign dead_ld = (state_d == S_DEAD) && ((state_q != S_DEAD) || dead_last);
  assign rx_ld   = (state_d == S_RX)   && ((state_q != S_RX)   || rx_last);

  dbf_seq_cnt #(.W(CNT_WD)) u_tx_cnt (
    .clk(clk), .rst(rst), .ld(tx_ld), .ld_val(tx_cfg), .dec(state_q == S_TX), .last(tx_last)
  );

  dbf_seq_cnt #(.W(CNT_WD)) u_dead_cnt (
    .clk(clk), .rst(rst), .ld(dead_ld), .ld_val(dead_cfg), .dec(state_q == S_DEAD), .last(dead_last)
  );

  dbf_seq_cnt #(.W(ADDR_WD)) u_rx_cnt (
    .clk(clk), .rst(rst), .ld(rx_ld), .ld_val(rx_cfg), .dec(state_q == S_RX), .last(rx_last)
  );

  always_comb begin
    addr_d = '0;
    case (state_d)
      S_LOAD: addr_d = bus.load_addr;
      S_RX: begin
        if (rx_ld)                          addr_d = '0;
        else if (addr_q != {ADDR_WD{1'b1}}) addr_d = addr_q + ADDR_WD'(1);
        else                                addr_d = addr_q;
      end
      default: addr_d = '0;
    endcase
  end

  // Host writes only count once the grant is already visible to the host.
  assign we_d         = (state_d == S_LOAD) && (state_q == S_LOAD) && bus.load_valid;
  assign tx_en_d      = (state_d == S_TX);
  assign start_d      = (state_d == S_RX);
  assign gnt_d        = (state_d == S_LOAD);
  assign busy_d       = (state_d != S_IDLE);
  assign line_done_d  = (state_d == S_RX) && (addr_d == rx_cfg - ADDR_WD'(1));
  assign frame_done_d = line_done_d && (line_idx_d == nl_cfg - LINE_WD'(1));
  assign trig_err_d   = bus.scan_trig && ((state_q != S_IDLE) || bus.load_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_lines_q  <= '0;
      tx_len_q     <= '0;
      dead_len_q   <= '0;
      rx_len_q     <= '0;
      line_idx_q   <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      tx_en_q      <= 1'b0;
      start_q      <= 1'b0;
      gnt_q        <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      trig_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_lines_q  <= num_lines_d;
      tx_len_q     <= tx_len_d;
      dead_len_q   <= dead_len_d;
      rx_len_q     <= rx_len_d;
      line_idx_q   <= line_idx_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      tx_en_q      <= tx_en_d;
      start_q      <= start_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      trig_err_q   <= trig_err_d;
    end
  end

  assign bus.load_gnt     = gnt_q;
  assign bus.tx_en        = tx_en_q;
  assign bus.start        = start_q;
  assign bus.dbf_lut_addr = addr_q;
  assign bus.dbf_lut_we   = we_q;
  assign bus.line_idx     = line_idx_q;
  assign bus.line_done    = line_done_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = busy_q;
  assign bus.trig_err     = trig_err_q;

endmodule

// File: tb/tb_dbf_scan_sequencer.sv
// Directed bench for dbf_scan_sequencer: frame-timeline model checked every cycle plus literal spot checks.
module tb_dbf_scan_sequencer;
  import dbf_scan_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbf_scan_sequencer_if bus();

  dbf_scan_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic tx_en;
    logic start;
    int   addr;
    int   line;
    logic line_done;
    logic frame_done;
  } cyc_t;

  cyc_t fq[$];
  logic e_tx = 0, e_st = 0, e_we = 0, e_gnt = 0, e_busy = 0, e_ld = 0, e_fd = 0, e_te = 0;
  int   e_addr = 0, e_line = 0;
  int   n_chk = 0, n_err = 0;
  bit   chk_en = 0;

  // Whole frame laid out as a list of cycles, straight from the line recipe.
  function automatic void build_frame(int nl, int tl, int dl, int rl);
    cyc_t c;
    if (nl == 0) nl = 1;
    if (rl == 0) rl = 1;
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < tl; i++) begin
        c = '{1'b1, 1'b0, 0, l, 1'b0, 1'b0};
        fq.push_back(c);
      end
      for (int i = 0; i < dl; i++) begin
        c = '{1'b0, 1'b0, 0, l, 1'b0, 1'b0};
        fq.push_back(c);
      end
      for (int i = 0; i < rl; i++) begin
        c = '{1'b0, 1'b1, i, l, i == rl - 1, (i == rl - 1) && (l == nl - 1)};
        fq.push_back(c);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic was_busy, was_gnt;
    cyc_t c;
    was_busy = e_busy;
    was_gnt  = e_gnt;
    {e_tx, e_st, e_we, e_gnt, e_busy, e_ld, e_fd, e_te} = '0;
    e_addr = 0;
    e_line = 0;
    if (rst) begin
      fq.delete();
    end else begin
      e_te = bus.scan_trig && (was_busy || bus.load_req);
      if (was_gnt) begin
        if (bus.load_req) begin
          e_gnt = 1; e_busy = 1; e_addr = int'(bus.load_addr); e_we = bus.load_valid;
        end
      end else if (!was_busy && bus.load_req) begin
        e_gnt = 1; e_busy = 1; e_addr = int'(bus.load_addr);
      end else if (!was_busy && bus.scan_trig) begin
        build_frame(int'(bus.num_lines), int'(bus.tx_len), int'(bus.dead_len), int'(bus.rx_len));
      end
      if (!was_gnt && !e_gnt && fq.size() > 0 && (was_busy || bus.scan_trig)) begin
        c = fq.pop_front();
        e_tx = c.tx_en; e_st = c.start; e_addr = c.addr; e_line = c.line;
        e_ld = c.line_done; e_fd = c.frame_done; e_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (bus.tx_en !== e_tx || bus.start !== e_st || bus.dbf_lut_we !== e_we ||
          bus.load_gnt !== e_gnt || bus.busy !== e_busy || bus.line_done !== e_ld ||
          bus.frame_done !== e_fd || bus.trig_err !== e_te ||
          int'(bus.dbf_lut_addr) !== e_addr || int'(bus.line_idx) !== e_line) begin
        n_err++;
        $display("FAIL cycle t=%0t actual tx=%b st=%b we=%b gnt=%b busy=%b ld=%b fd=%b te=%b addr=%0d line=%0d required tx=%b st=%b we=%b gnt=%b busy=%b ld=%b fd=%b te=%b addr=%0d line=%0d",
                 $time, bus.tx_en, bus.start, bus.dbf_lut_we, bus.load_gnt, bus.busy, bus.line_done,
                 bus.frame_done, bus.trig_err, bus.dbf_lut_addr, bus.line_idx,
                 e_tx, e_st, e_we, e_gnt, e_busy, e_ld, e_fd, e_te, e_addr, e_line);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int nl, input int tl, input int dl, input int rl);
    bus.num_lines = LINE_WD'(nl);
    bus.tx_len    = CNT_WD'(tl);
    bus.dead_len  = CNT_WD'(dl);
    bus.rx_len    = ADDR_WD'(rl);
  endtask

  task automatic trig();
    bus.scan_trig = 1'b1;
    tick();
    bus.scan_trig = 1'b0;
  endtask

  task automatic wait_rx(input int a, input int lim, input string nm);
    int n = 0;
    while (!(bus.start === 1'b1 && int'(bus.dbf_lut_addr) == a) && n < lim) begin
      tick();
      n++;
    end
    chk(nm, int'(bus.start === 1'b1 && int'(bus.dbf_lut_addr) == a), 1);
  endtask

  task automatic wait_fd(input int lim, input string nm);
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(nm, int'(bus.frame_done === 1'b1), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tx, n_st, n_ld, n_fd, first_st, fd_addr;
    rst = 1'b1;
    bus.scan_trig = 0; bus.load_req = 0; bus.load_valid = 0; bus.load_addr = '0;
    cfg(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_addr", int'(bus.dbf_lut_addr), 0);
    chk("rst_tx_en", bus.tx_en, 0);
    rst = 1'b0;
    chk_en = 1;
    tick();

    // Two lines, all phases present.
    cfg(2, 4, 3, 8);
    trig();
    n_tx = 0; n_st = 0; n_ld = 0; n_fd = 0; first_st = -1; fd_addr = -1;
    for (int i = 0; i < 40; i++) begin
      n_tx += int'(bus.tx_en);
      n_ld += int'(bus.line_done);
      n_fd += int'(bus.frame_done);
      if (bus.start) begin
        n_st++;
        if (first_st < 0) first_st = i;
      end
      if (bus.frame_done) fd_addr = int'(bus.dbf_lut_addr);
      tick();
    end
    chk("t1_tx_cycles", n_tx, 8);
    chk("t1_rx_cycles", n_st, 16);
    chk("t1_line_done", n_ld, 2);
    chk("t1_frame_done", n_fd, 1);
    chk("t1_first_rx", first_st, 7);
    chk("t1_fd_addr", fd_addr, 7);
    chk("t1_idle", bus.busy, 0);

    // Minimal line: everything lands on a single RX cycle; num_lines=0 acts as 1.
    cfg(0, 0, 0, 1);
    trig();
    chk("t2_start", bus.start, 1);
    chk("t2_addr", int'(bus.dbf_lut_addr), 0);
    chk("t2_line_done", bus.line_done, 1);
    chk("t2_frame_done", bus.frame_done, 1);
    tick();
    chk("t2_idle", bus.busy, 0);

    // Host LUT load with a rejected trigger.
    bus.load_req = 1;
    tick();
    chk("t3_gnt", bus.load_gnt, 1);
    bus.load_valid = 1; bus.load_addr = 10'd5;
    tick();
    chk("t3_we5", bus.dbf_lut_we, 1);
    chk("t3_addr5", int'(bus.dbf_lut_addr), 5);
    bus.load_addr = 10'd6;
    tick();
    bus.load_addr = 10'd7;
    tick();
    chk("t3_addr7", int'(bus.dbf_lut_addr), 7);
    bus.load_valid = 0;
    cfg(1, 2, 1, 2);
    trig();
    chk("t3_trig_err", bus.trig_err, 1);
    chk("t3_no_tx", bus.tx_en, 0);
    bus.load_req = 0;
    tick();
    chk("t3_gnt_drop", bus.load_gnt, 0);
    chk("t3_idle", bus.busy, 0);

    // Same-cycle load_req and scan_trig: load wins.
    bus.load_req = 1;
    trig();
    chk("t6_trig_err", bus.trig_err, 1);
    chk("t6_gnt", bus.load_gnt, 1);
    chk("t6_no_tx", bus.tx_en, 0);
    tick();
    bus.load_req = 0;
    repeat (2) tick();

    // Retrigger mid-RX is rejected without disturbing the frame.
    cfg(1, 2, 1, 6);
    trig();
    wait_rx(2, 50, "t4_reach_rx2");
    trig();
    chk("t4_trig_err", bus.trig_err, 1);
    chk("t4_addr3", int'(bus.dbf_lut_addr), 3);
    wait_fd(50, "t4_fd_seen");
    chk("t4_fd_addr", int'(bus.dbf_lut_addr), 5);
    tick();

    // Asynchronous reset mid-RX, then a clean restart.
    cfg(2, 3, 2, 8);
    trig();
    wait_rx(3, 60, "t5_reach_rx3");
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_start", bus.start, 0);
    chk("t5_rst_addr", int'(bus.dbf_lut_addr), 0);
    chk("t5_rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    trig();
    chk("t5_restart_tx", bus.tx_en, 1);
    chk("t5_restart_line", int'(bus.line_idx), 0);
    wait_rx(0, 20, "t5_restart_rx0");
    chk("t5_rx_line", int'(bus.line_idx), 0);
    wait_fd(80, "t5_fd_seen");
    tick();

    // Largest rx_len reaches the top address without wrapping.
    cfg(1, 0, 0, 1023);
    trig();
    wait_fd(1100, "t7_fd_seen");
    chk("t7_max_addr", int'(bus.dbf_lut_addr), 1022);
    tick();

    // rx_len=0 acts as 1; TX skipped, DEAD kept.
    cfg(1, 0, 2, 0);
    trig();
    chk("t8_dead_busy", bus.busy, 1);
    chk("t8_dead_tx", bus.tx_en, 0);
    repeat (2) tick();
    chk("t8_rx_fd", bus.frame_done, 1);

    repeat (3) tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
